i2s_sample_tx: RTL and testbench

I2S_SAMPLE_TX -- requirements
Module: i2s_sample_tx

---
 rtl/i2s_sample_tx.sv | 209 ++++++++++++++++++++
 tb/tb_i2s_sample_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: streams buffered samples as I2S (left/right slots, MSB first,
// one bit of delay after each WS change). Samples are prefetched one slot
// ahead from a registered-output buffer; a low-watermark fetch substitutes
// silence and is counted as an underrun.
module i2s_sample_tx #(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] fifo_dout,
    input  logic                fifo_lw,
    output logic                fifo_pop,
    output logic                sclk,
    output logic                ws,
    output logic                sd,
    output logic                busy,
    output logic                underrun,
    output logic [7:0]          underrun_cnt
);

    localparam int unsigned KW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int unsigned DW = $clog2(CLK_DIV);

    localparam logic [KW-1:0] K_LAST      = KW'(SLOT_W - 1);
    localparam logic [KW-1:0] K_DATA_LAST = KW'(SAMPLE_W);
    localparam logic [KW-1:0] K_FETCH     = KW'(SAMPLE_W + 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [KW-1:0]       k_q, k_d;
    logic                sclk_q, sclk_d;
    logic                ws_q, ws_d;
    logic                sd_q, sd_d;
    logic                pop_q, pop_d;
    logic                underrun_q, underrun_d;
    logic                skip_q, skip_d;
    logic [7:0]          ucnt_q, ucnt_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] next_q, next_d;

    logic                half_tick;
    logic                fall_tick;
    logic                stop_now;
    logic [KW-1:0]       k_next;
    logic                fetch_req;
    logic                fetch_to_shift;

    assign half_tick = (div_q == DIV_LAST);
    assign fall_tick = half_tick & sclk_q;
    assign k_next    = (k_q == K_LAST) ? '0 : k_q + KW'(1);
    // Stopping is decided by the latest enable sample at the right slot's end,
    // so a reassertion before then cancels the stop.
    assign stop_now  = fall_tick & (k_q == K_LAST) & ws_q & ~enable;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            k_q        <= '0;
            sclk_q     <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            pop_q      <= 1'b0;
            underrun_q <= 1'b0;
            skip_q     <= 1'b0;
            ucnt_q     <= '0;
            shift_q    <= '0;
            next_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            k_q        <= k_d;
            sclk_q     <= sclk_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            pop_q      <= pop_d;
            underrun_q <= underrun_d;
            skip_q     <= skip_d;
            ucnt_q     <= ucnt_d;
            shift_q    <= shift_d;
            next_q     <= next_d;
        end
    end

    // Next-state logic for the streaming FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable && !fifo_lw) state_d = PRIME;
            PRIME:   state_d = RUN;
            RUN:     if (stop_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bit clock, slot sequencing, serialisation and sample fetch.
    always_comb begin
        div_d          = div_q;
        k_d            = k_q;
        sclk_d         = sclk_q;
        ws_d           = ws_q;
        sd_d           = sd_q;
        shift_d        = shift_q;
        next_d         = next_q;
        skip_d         = skip_q;
        ucnt_d         = ucnt_q;
        pop_d          = 1'b0;
        underrun_d     = 1'b0;
        fetch_req      = 1'b0;
        fetch_to_shift = 1'b0;

        unique case (state_q)
            IDLE: begin
                div_d  = '0;
                k_d    = '0;
                sclk_d = 1'b0;
                ws_d   = 1'b0;
                sd_d   = 1'b0;
                skip_d = 1'b0;
            end
            PRIME: begin
                // The first left slot starts now, so the head word goes
                // straight into the shifter as well as next_sample.
                div_d   = '0;
                k_d     = '0;
                sclk_d  = 1'b0;
                ws_d    = 1'b0;
                sd_d    = 1'b0;
                skip_d  = 1'b0;
                next_d  = fifo_dout;
                shift_d = fifo_dout;
                pop_d   = 1'b1;
            end
            RUN: begin
                if (half_tick) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                end else begin
                    div_d = div_q + DW'(1);
                end
                if (fall_tick) begin
                    k_d  = k_next;
                    sd_d = 1'b0;
                    if (k_q == K_LAST) begin
                        if (stop_now) begin
                            ws_d   = 1'b0;
                            skip_d = 1'b0;
                        end else begin
                            ws_d = ~ws_q;
                            // A stop that was cancelled after the right-slot
                            // fetch was skipped leaves next_sample stale;
                            // fetch straight into the shifter instead.
                            if (skip_q) begin
                                fetch_req      = 1'b1;
                                fetch_to_shift = 1'b1;
                                skip_d         = 1'b0;
                            end else begin
                                shift_d = next_q;
                            end
                        end
                    end else if (k_next <= K_DATA_LAST) begin
                        sd_d    = shift_q[SAMPLE_W-1];
                        shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
                    end else if (k_next == K_FETCH) begin
                        if (ws_q && !enable) skip_d = 1'b1;
                        else                 fetch_req = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (fetch_req) begin
            if (fifo_lw) begin
                underrun_d = 1'b1;
                if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
                if (fetch_to_shift) shift_d = '0;
                else                next_d  = '0;
            end else begin
                pop_d = 1'b1;
                if (fetch_to_shift) shift_d = fifo_dout;
                else                next_d  = fifo_dout;
            end
        end
    end

    // Output drive from registered state.
    always_comb begin
        fifo_pop     = pop_q;
        sclk         = sclk_q;
        ws           = ws_q;
        sd           = sd_q;
        busy         = (state_q != IDLE);
        underrun     = underrun_q;
        underrun_cnt = ucnt_q;
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Directed bench for i2s_sample_tx: a registered buffer model feeds the DUT,
// each popped word (or silence on underrun) is queued as the expected slot
// content, and a serial monitor rebuilds slots from sclk/ws/sd to compare.
module tb_i2s_sample_tx;

    localparam int SW = 24;
    localparam int SL = 32;
    localparam int CD = 2;

    logic          clk      = 1'b0;
    logic          clear_n  = 1'b0;
    logic          enable   = 1'b0;
    logic          fifo_lw  = 1'b0;
    logic [SW-1:0] fifo_dout = 24'hA5F00F;
    logic          fifo_pop, sclk, ws, sd, busy, underrun;
    logic [7:0]    underrun_cnt;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] src_q[$];
    logic [SW-1:0] exp_q[$];

    int            cyc       = 0;
    int            pop_total = 0;
    int            ucount    = 0;
    int            slots     = 0;
    int            mon_k     = -1;
    int            last_rise = -1;
    int            left_start = -1;
    logic          exp_ws    = 1'b0;
    logic          prev_sclk = 1'b0;
    logic          prev_pop  = 1'b0;
    logic [SW-1:0] word      = '0;

    always #5 clk = ~clk;

    i2s_sample_tx #(
        .SAMPLE_W(SW),
        .SLOT_W  (SL),
        .CLK_DIV (CD)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .enable      (enable),
        .fifo_dout   (fifo_dout),
        .fifo_lw     (fifo_lw),
        .fifo_pop    (fifo_pop),
        .sclk        (sclk),
        .ws          (ws),
        .sd          (sd),
        .busy        (busy),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buffer model with registered head word; scoreboard producer.
    always @(posedge clk) begin
        cyc++;
        if (fifo_pop) begin
            exp_q.push_back(fifo_dout);
            pop_total++;
            if (src_q.size() > 0) fifo_dout <= src_q.pop_front();
        end
        if (underrun) exp_q.push_back('0);
    end

    // Serial monitor and scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!clear_n || !busy) begin
            mon_k      = -1;
            exp_ws     = 1'b0;
            prev_sclk  = 1'b0;
            last_rise  = -1;
            left_start = -1;
        end else begin
            if (sclk && !prev_sclk) begin
                if (last_rise >= 0) check(cyc - last_rise, 4, "sclk_period");
                last_rise = cyc;
                if (mon_k < 0 || mon_k == SL - 1) begin
                    mon_k = 0;
                    word  = '0;
                    check(ws, exp_ws, "ws_slot_start");
                    check(sd, 0, "sd_k0");
                    if (ws == 1'b0) begin
                        if (left_start >= 0) check(cyc - left_start, 256, "frame_len");
                        left_start = cyc;
                    end
                end else begin
                    mon_k++;
                    check(ws, exp_ws, "ws_stable");
                    if (mon_k <= SW) word = {word[SW-2:0], sd};
                    else             check(sd, 0, "sd_pad");
                    if (mon_k == SL - 1) begin
                        check(exp_q.size() > 0, 1, "sb_nonempty");
                        if (exp_q.size() > 0) check(word, exp_q.pop_front(), "slot_word");
                        exp_ws = ~exp_ws;
                        slots++;
                    end
                end
            end
            prev_sclk = sclk;
        end
        if (fifo_pop) begin
            check(prev_pop, 0, "pop_spacing");
            check((mon_k == -1) || (mon_k == SW), 1, "pop_position");
        end
        prev_pop = fifo_pop;
        if (underrun) begin
            ucount++;
            check(underrun_cnt, (ucount > 255) ? 255 : ucount, "underrun_cnt");
        end
    end

    initial begin
        int p0;
        src_q = {24'hA5F00F, 24'h000001, 24'h800000, 24'h000001,
                 24'h800000, 24'h000001, 24'h800000, 24'h000001};

        // Reset and idle
        #1;
        check({fifo_pop, sclk, ws, sd, busy, underrun}, 0, "reset_outs");
        check(underrun_cnt, 0, "reset_cnt");
        repeat (3) @(negedge clk);
        clear_n = 1'b1;
        repeat (20) @(negedge clk);
        check(busy, 0, "idle_busy");
        check({sclk, ws, sd, fifo_pop}, 0, "idle_outs");
        check(pop_total, 0, "idle_nopop");

        // Basic frames and channel alternation
        enable = 1'b1;
        for (int i = 0; i < 3000 && slots < 7; i++) @(negedge clk);
        check(slots >= 7, 1, "basic_progress");

        // Graceful stop from the middle of a left slot
        for (int i = 0; i < 600 && !(mon_k == 10 && ws == 1'b0); i++) @(negedge clk);
        check(mon_k == 10 && ws == 1'b0, 1, "stop_reach_left");
        enable = 1'b0;
        p0 = pop_total;
        for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
        check(busy, 0, "stop_idle");
        check(pop_total - p0, 1, "stop_pops");
        check({sclk, ws, sd}, 0, "stop_outs");
        check(exp_q.size(), 0, "stop_sb_drained");

        // Underruns and counter saturation
        fifo_lw = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 1000 && !(mon_k == 10 && ws == 1'b0); i++) @(negedge clk);
        check(mon_k == 10 && ws == 1'b0, 1, "ur_reach_left");
        fifo_lw = 1'b1;
        p0 = pop_total;
        for (int i = 0; i < 400 && ucount < 1; i++) @(negedge clk);
        check(underrun_cnt, 1, "underrun_first");
        for (int i = 0; i < 45000 && ucount < 300; i++) @(negedge clk);
        check(ucount >= 300, 1, "underrun_300");
        check(underrun_cnt, 255, "underrun_sat");
        check(pop_total - p0, 0, "underrun_nopop");

        // Asynchronous reset at k=25 of a right slot
        fifo_lw = 1'b0;
        for (int i = 0; i < 1000 && !(mon_k == SW + 1 && ws == 1'b1); i++) @(negedge clk);
        check(mon_k == SW + 1 && ws == 1'b1, 1, "rst_reach_right");
        #1 clear_n = 1'b0;
        #1;
        check({fifo_pop, sclk, ws, sd, busy, underrun}, 0, "midrst_outs");
        check(underrun_cnt, 0, "midrst_cnt");
        exp_q.delete();
        p0 = pop_total;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        clear_n = 1'b1;
        repeat (10) @(negedge clk);
        check(pop_total - p0, 0, "midrst_nopop");
        check(busy, 0, "midrst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
